pendigits_eval_sequencer: RTL and testbench

Synchronous evaluation sequencer for the combinational pendigits ternary classifiers. It reads test vectors and golden labels from an external synchronous ROM and drives `features` into the classifier. It samples `prediction` after a programmable settle time, then emits one result beat per test case over a valid/ready handshake. It keeps a running count of correct predictions, so silicon or FPGA builds can measure accuracy without a simulator printing results.

---
 rtl/pendigits_eval_sequencer.sv | 119 +++++++++++
 tb/tb_pendigits_eval_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pendigits_eval_sequencer.sv
// Evaluation sequencer for the pendigits classifiers: fetches ROM test cases, drives the
// classifier, samples its prediction after a settle delay and streams scored result beats.
module pendigits_eval_sequencer #(
  parameter int unsigned FEAT_CNT      = 16,
  parameter int unsigned FEAT_BITS     = 4,
  parameter int unsigned CLASS_CNT     = 10,
  parameter int unsigned TEST_CNT      = 1000,
  parameter int unsigned SETTLE_CYCLES = 5,
  localparam int unsigned IDX_BITS     = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1,
  localparam int unsigned CNT_BITS     = $clog2(TEST_CNT + 1),
  localparam int unsigned PRED_BITS    = $clog2(CLASS_CNT),
  localparam int unsigned WORD_BITS    = FEAT_CNT * FEAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IDX_BITS-1:0]  tc_addr,
  input  logic [WORD_BITS-1:0] tc_data,
  input  logic [PRED_BITS-1:0] tc_label,
  output logic [WORD_BITS-1:0] features,
  input  logic [PRED_BITS-1:0] prediction,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_BITS-1:0]  res_index,
  output logic [PRED_BITS-1:0] res_pred,
  output logic                 res_correct,
  output logic [CNT_BITS-1:0]  correct_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned SETTLE_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_BITS-1:0]    LastIdx    = IDX_BITS'(TEST_CNT - 1);
  localparam logic [SETTLE_BITS-1:0] SettleLoad = SETTLE_BITS'(SETTLE_CYCLES - 1);
  // One extra bit so a class count that is a power of two still compares correctly.
  localparam logic [PRED_BITS:0]     ClassLim   = (PRED_BITS + 1)'(CLASS_CNT);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLoad,
    StSettle,
    StReport,
    StDone
  } state_e;

  state_e                 state_q;
  logic [IDX_BITS-1:0]    idx_q;
  logic [PRED_BITS-1:0]   label_q;
  logic [SETTLE_BITS-1:0] settle_q;
  logic                   pred_ok;

  assign pred_ok   = (prediction == label_q) && ({1'b0, prediction} < ClassLim);
  assign tc_addr   = idx_q;
  assign res_index = idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      label_q     <= '0;
      settle_q    <= '0;
      features    <= '0;
      res_valid   <= 1'b0;
      res_pred    <= '0;
      res_correct <= 1'b0;
      correct_cnt <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StAddr;
            idx_q       <= '0;
            correct_cnt <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        StAddr: state_q <= StLoad;
        StLoad: begin
          features <= tc_data;
          label_q  <= tc_label;
          settle_q <= SettleLoad;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == '0) begin
            res_pred    <= prediction;
            res_correct <= pred_ok;
            res_valid   <= 1'b1;
            state_q     <= StReport;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StReport: begin
          // Beat fields stay frozen until the consumer takes the beat.
          if (res_ready) begin
            res_valid   <= 1'b0;
            correct_cnt <= correct_cnt + CNT_BITS'(res_correct);
            if (idx_q == LastIdx) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StAddr;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pendigits_eval_sequencer.sv
// Directed bench for pendigits_eval_sequencer: 4 test cases, behavioural ROM and classifier.
module tb_pendigits_eval_sequencer;

  localparam int unsigned FEAT_CNT      = 16;
  localparam int unsigned FEAT_BITS     = 4;
  localparam int unsigned CLASS_CNT     = 10;
  localparam int unsigned TEST_CNT      = 4;
  localparam int unsigned SETTLE_CYCLES = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  tc_addr;
  logic [63:0] tc_data = '0;
  logic [3:0]  tc_label = '0;
  logic [63:0] features;
  logic [3:0]  prediction;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [1:0]  res_index;
  logic [3:0]  res_pred;
  logic        res_correct;
  logic [2:0]  correct_cnt;
  logic        busy;
  logic        done;

  logic [3:0] label_tab [4];
  logic       oor_mode = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  pendigits_eval_sequencer #(
    .FEAT_CNT      (FEAT_CNT),
    .FEAT_BITS     (FEAT_BITS),
    .CLASS_CNT     (CLASS_CNT),
    .TEST_CNT      (TEST_CNT),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tc_addr     (tc_addr),
    .tc_data     (tc_data),
    .tc_label    (tc_label),
    .features    (features),
    .prediction  (prediction),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_index   (res_index),
    .res_pred    (res_pred),
    .res_correct (res_correct),
    .correct_cnt (correct_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input int i);
    logic [63:0] w;
    w = 64'hFEDC_BA98_7654_3210;
    w[3:0] = 4'(i);
    return w;
  endfunction

  // Synchronous ROM: one-cycle latency from tc_addr.
  always @(posedge clk) begin
    tc_data  <= rom_word(int'(tc_addr));
    tc_label <= label_tab[tc_addr];
  end

  // Classifier echoes the label except for test case 2; oor_mode forces class 12.
  always_comb begin
    prediction = label_tab[features[1:0]];
    if (features[3:0] == 4'd2) prediction = 4'd1;
    if (oor_mode) prediction = 4'd12;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run(input int stall, input bit glitch, input int exp_pred[4],
                     input bit exp_corr[4], input int exp_cnt, input int exp_cycles);
    int cycles;
    int beat;
    int stall_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    beat = 0;
    stall_cnt = 0;
    check("run_busy", busy, 1);
    check("run_done_clr", done, 0);
    check("run_cnt_clr", correct_cnt, 0);
    check("run_addr0", tc_addr, 0);
    while (!done && cycles < 500) begin
      if (cycles == 3) check("features0", features, rom_word(0));
      start = glitch && (cycles == 4);
      if (res_valid) begin
        if (beat > 3) begin
          check("extra_beat", beat, 3);
          res_ready = 1'b1;
        end else begin
          check("res_index", res_index, beat);
          check("res_pred", res_pred, exp_pred[beat]);
          check("res_correct", res_correct, exp_corr[beat]);
          if (stall_cnt < stall) begin
            res_ready = 1'b0;
            stall_cnt++;
          end else begin
            res_ready = 1'b1;
            beat++;
            stall_cnt = 0;
          end
        end
      end else begin
        res_ready = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check("done_cycle", cycles, exp_cycles);
    check("beat_count", beat, 4);
    check("correct_cnt", correct_cnt, exp_cnt);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    int  nom_pred[4];
    bit  nom_corr[4];
    int  oor_pred[4];
    bit  oor_corr[4];
    label_tab = '{4'd3, 4'd7, 4'd0, 4'd9};
    nom_pred  = '{3, 7, 1, 9};
    nom_corr  = '{1'b1, 1'b1, 1'b0, 1'b1};
    oor_pred  = '{12, 12, 12, 12};
    oor_corr  = '{1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Abort mid-run while in SETTLE.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tc_addr", tc_addr, 0);
    check("rst_features", features, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_index", res_index, 0);
    check("rst_res_pred", res_pred, 0);
    check("rst_res_correct", res_correct, 0);
    check("rst_correct_cnt", correct_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_beat_after_rst", res_valid, 0);

    run(0, 1'b0, nom_pred, nom_corr, 3, 33);
    check("done_held", done, 1);
    run(10, 1'b0, nom_pred, nom_corr, 3, 73);
    run(0, 1'b1, nom_pred, nom_corr, 3, 33);
    check("features_held", features, rom_word(3));

    label_tab = '{4'd12, 4'd12, 4'd12, 4'd12};
    oor_mode  = 1'b1;
    run(0, 1'b0, oor_pred, oor_corr, 0, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
